// File: rtl/tdc_interval_fifo.sv
// TDC interval measurement: start/stop fine codes plus a coarse cycle count
// form a start-to-stop interval in tap units, buffered in a FWFT FIFO.
module tdc_interval_fifo #(
    parameter int NUM_TAPS = 32,
    parameter int FINE_W   = $clog2(NUM_TAPS),
    parameter int COARSE_W = 16,
    parameter int DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_valid,
    input  logic [FINE_W-1:0]            start_fine,
    input  logic                         stop_valid,
    input  logic [FINE_W-1:0]            stop_fine,
    output logic                         busy,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [COARSE_W+FINE_W-1:0]   m_interval,
    output logic                         m_overrange,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [7:0]                   overflow_cnt
);

    // state | meaning
    // IDLE  | waiting for a start strobe, stop strobes ignored
    // ARMED | coarse counter running, waiting for stop or timeout

    localparam int IW = COARSE_W + FINE_W;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t              state_q, state_d;
    logic [COARSE_W-1:0] cnt_q, cnt_d;
    logic [FINE_W-1:0]   start_q, start_d;
    logic [IW:0]         mem_q [DEPTH];
    logic [IW:0]         mem_d [DEPTH];
    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          ovf_q, ovf_d;

    logic                push;
    logic                pop;
    logic                accept;
    logic [IW:0]         rec;
    logic [IW-1:0]       interval_calc;
    logic [IW:0]         head;

    // NUM_TAPS is a power of two, so k*NUM_TAPS is k shifted left by FINE_W
    assign interval_calc = {cnt_q, {FINE_W{1'b0}}} + IW'(stop_fine) - IW'(start_q);

    // Measurement FSM: arms on start, emits a record on stop or counter terminal count.
    // The start edge counts as the first coarse step, so the register holds k
    // during the k-th cycle after the start strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        push    = 1'b0;
        rec     = '0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    start_d = start_fine;
                    cnt_d   = COARSE_W'(1);
                    state_d = ARMED;
                end
            end
            ARMED: begin
                cnt_d = cnt_q + COARSE_W'(1);
                if (stop_valid) begin
                    push    = 1'b1;
                    rec     = {1'b0, interval_calc};
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '1) begin
                    push    = 1'b1;
                    rec     = {1'b1, {IW{1'b1}}};
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when the head pops in the same cycle
    always_comb begin
        pop     = (count_q != '0) && m_ready;
        accept  = push && ((count_q != CW'(DEPTH)) || pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (accept) begin
            mem_d[wr_q] = rec;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CW'(1);
        end
        if (push && !accept && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    // State and storage registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= '0;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign head         = mem_q[rd_q];
    assign busy         = (state_q == ARMED);
    assign m_valid      = (count_q != '0);
    assign m_interval   = m_valid ? head[IW-1:0] : '0;
    assign m_overrange  = m_valid & head[IW];
    assign fifo_count   = count_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_tdc_interval_fifo.sv
// Scoreboard bench for tdc_interval_fifo with a short coarse counter so the
// timeout path is reachable quickly.
module tb_tdc_interval_fifo;

    localparam int NUM_TAPS = 32;
    localparam int FINE_W   = 5;
    localparam int COARSE_W = 4;
    localparam int DEPTH    = 8;
    localparam int IW       = COARSE_W + FINE_W;
    localparam int TMO      = (1 << COARSE_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_valid, stop_valid, m_ready;
    logic [FINE_W-1:0] start_fine, stop_fine;
    logic              busy, m_valid, m_overrange;
    logic [IW-1:0]     m_interval;
    logic [3:0]        fifo_count;
    logic [7:0]        overflow_cnt;

    tdc_interval_fifo #(
        .NUM_TAPS(NUM_TAPS), .FINE_W(FINE_W), .COARSE_W(COARSE_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_fine(start_fine),
        .stop_valid(stop_valid), .stop_fine(stop_fine),
        .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
        .m_interval(m_interval), .m_overrange(m_overrange),
        .fifo_count(fifo_count), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // scoreboard: expected records in FIFO order, plus expected drop count
    logic [IW:0] sb_q[$];
    int          ovf_m = 0;
    bit          exp_push = 1'b0;
    logic [IW:0] exp_rec = '0;

    // Reference FIFO: accepts the expected record when room exists or the head pops
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            ovf_m = 0;
        end else begin
            automatic bit pop_m = (sb_q.size() != 0) && m_ready;
            automatic bit acc_m = exp_push && ((sb_q.size() < DEPTH) || pop_m);
            if (pop_m) void'(sb_q.pop_front());
            if (acc_m) sb_q.push_back(exp_rec);
            else if (exp_push && ovf_m < 255) ovf_m++;
        end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("fifo_count", fifo_count, sb_q.size());
            check_eq("m_valid", m_valid, (sb_q.size() != 0) ? 1 : 0);
            check_eq("overflow_cnt", overflow_cnt, ovf_m);
            if (sb_q.size() != 0) begin
                check_eq("head_interval", m_interval, sb_q[0][IW-1:0]);
                check_eq("head_overrange", m_overrange, sb_q[0][IW]);
            end else begin
                check_eq("empty_interval", m_interval, 0);
                check_eq("empty_overrange", m_overrange, 0);
            end
        end
    end

    // One measurement: start strobe, stop (or timeout) in the gap-th cycle after it.
    // Returns at the negedge of the first cycle with busy expected low.
    task automatic measure(input int sf, input int pf, input int gap, input bit do_stop,
                           input bit stop_with_start, input bit rdy_at_stop);
        start_valid = 1'b1;
        start_fine  = FINE_W'(sf);
        stop_valid  = stop_with_start;
        stop_fine   = '0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        stop_valid  = 1'b0;
        for (int k = 1; k <= gap; k++) begin
            if (k == gap) begin
                stop_valid = do_stop;
                stop_fine  = FINE_W'(pf);
                exp_push   = 1'b1;
                exp_rec    = do_stop ? {1'b0, IW'(gap * NUM_TAPS + pf - sf)} : {1'b1, {IW{1'b1}}};
                if (rdy_at_stop) m_ready = 1'b1;
            end
            @(negedge clk);
            check_eq("busy_armed", busy, 1);
            @(posedge clk); #1;
            stop_valid = 1'b0;
            exp_push   = 1'b0;
            if (rdy_at_stop) m_ready = 1'b0;
        end
        @(negedge clk);
        check_eq("busy_idle", busy, 0);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check_eq("drain_empty", sb_q.size(), 0);
        check_eq("drain_m_valid", m_valid, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; stop_valid = 1'b0;
        start_fine = '0; stop_fine = '0; m_ready = 1'b0;
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ovf", overflow_cnt, 0);
        check_eq("rst_interval", m_interval, 0);
        @(negedge clk); rst_n = 1'b1;
        m_ready = 1'b1;

        // basic: 3*32 + 4 - 10 = 90
        measure(10, 4, 3, 1'b1, 1'b0, 1'b0);
        // stop alongside start ignored; 32 + 0 - 31 = 1
        measure(31, 0, 1, 1'b1, 1'b1, 1'b0);
        // timeout: overrange record of all ones
        measure(0, 0, TMO, 1'b0, 1'b0, 1'b0);
        // stop in the terminal-count cycle wins: 15*32 + 7 = 487
        measure(0, 7, TMO, 1'b1, 1'b0, 1'b0);
        measure(17, 17, 2, 1'b1, 1'b0, 1'b0);
        drain();

        // nine measurements into a stalled FIFO: last one dropped
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) measure((i * 7) % 32, (i * 11) % 32, i + 1, 1'b1, 1'b0, 1'b0);
        check_eq("full_count", fifo_count, 8);
        check_eq("full_ovf", overflow_cnt, 1);
        drain();

        // full FIFO with push and pop together, across pointer wrap
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) measure(i, 31 - i, 2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) measure(3 * i, 20, 3, 1'b1, 1'b0, 1'b1);
        check_eq("pushpop_count", fifo_count, 8);
        check_eq("pushpop_ovf", overflow_cnt, 1);
        drain();

        // async reset while armed with three records queued
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) measure(i + 1, 9, 2, 1'b1, 1'b0, 1'b0);
        start_valid = 1'b1; start_fine = FINE_W'(12);
        @(posedge clk); #1 start_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_m_valid", m_valid, 0);
        check_eq("arst_count", fifo_count, 0);
        check_eq("arst_ovf", overflow_cnt, 0);
        check_eq("arst_interval", m_interval, 0);
        check_eq("arst_overrange", m_overrange, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        // 4*32 + 20 - 5 = 143
        measure(5, 20, 4, 1'b1, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
